data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-requester controller in front of the byte-addressed data memory: port 0 (CPU load/store unit) and port 1 (DMA/debug loader). Arbitrates round-robin, latches the winning request, and drives the memory's read-enable, write-enable, address, mode and write-data pins for exactly one cycle. Returns read data or a write acknowledge with fixed latency, and rejects out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 2048, size of the byte array behind the memory; addresses at or above this are out of range.
ADDR_W, 16, address width on all ports.
DATA_W, 16, data width on all ports.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
p0_req, p1_req  input  1  request; held high until the matching ack.
p0_we, p1_we  input  1  1 = write, 0 = read.
p0_mode, p1_mode  input  2  0 = 16-bit word (big-endian: byte addr holds bits 15:8, addr+1 holds bits 7:0); 1 = byte; 2 and 3 are illegal.
p0_addr, p1_addr  input  ADDR_W  byte address.
p0_wdata, p1_wdata  input  DATA_W  write data; byte mode uses bits 7:0.
p0_ack, p1_ack  output  1  one-cycle completion pulse.
p0_rdata, p1_rdata  output  DATA_W  read data, valid only while the matching ack is high.
p0_err, p1_err  output  1  high with ack when the access was rejected.
mem_rd  output  1  memory read enable.
mem_wn  output  1  memory write enable.
mem_address  output  ADDR_W  memory byte address.
mem_mode  output  2  memory access mode.
mem_write_data  output  DATA_W  memory write data.
mem_read_data  input  DATA_W  registered read data from memory.
busy  output  1  high in any state other than IDLE.
grant_id  output  1  owner of the current or last transaction.

Behaviour:
Reset values:
- All outputs 0; state = IDLE.
- Round-robin pointer favours port 0.

State machine:
- IDLE: if any req is high, pick a winner and latch its we, mode, addr and wdata; set grant_id.
  - Legal request: go to ACCESS.
  - Illegal request: go to RESP with err set. Illegal means mode greater than 1, addr at or above MEM_BYTES, or word mode with addr = MEM_BYTES-1 (no wrap to 0).
- ACCESS (exactly 1 cycle): mem_address, mem_mode and mem_write_data driven from the latched request.
  - Read: mem_rd = 1, mem_wn = 0.
  - Write: mem_rd = 0, mem_wn = 1.
  - All memory pins come from registers, so they are stable across the falling edge, where the memory commits writes.
  - Next state: RESP.
- RESP (1 cycle): mem_rd = mem_wn = 0.
  - Owner's ack = 1.
  - Owner's rdata = mem_read_data for reads. Byte reads return the value zero-extended, bits 15:8 = 0. Writes and errors return 0.
  - Owner's err set if the request was rejected.
  - Next state: IDLE.

Latency:
- Request sampled at edge N; ack is high in the cycle after edge N+2. Legal transactions take 3 cycles from req to ack.
- Rejected requests: ack is high after edge N+1.
- Back-to-back throughput is one transaction per 3 cycles.

Arbitration:
- Only one request: it wins.
- Both requesting: the port not served last wins. The pointer updates at grant, including for rejected requests.
- The loser's req stays pending; no starvation.

Outside the granted transaction:
- Requester fields are ignored once latched; changes after grant have no effect.
- Dropping req before ack is a protocol violation. The transaction still completes and ack still pulses.
- mem_rd and mem_wn are never both 1 and never high outside ACCESS.

Reset mid-operation:
- State returns to IDLE at the sampling edge and no ack is issued.
- A write whose ACCESS cycle has already passed a falling edge is committed in memory.

Optional Feature:
DATA_MEM_ARB_CPU_PRIORITY_EN:
- Defined: fixed priority; port 0 always wins a simultaneous request. The round-robin pointer is removed.
- Undefined: round-robin as described above.

Decomposition:
- Package data_mem_pkg holds:
  - mode constants MODE_WORD = 2'd0 and MODE_BYTE = 2'd1;
  - state encodings IDLE/ACCESS/RESP;
  - a request struct typedef {we, mode, addr, wdata}.
- One natural sub-module, rr_arbiter2: two-input round-robin picker with pointer update on grant. The feature macro switches it to fixed priority.

Test Plan:
- Port 0 word write 0xBEEF at addr 0x0010, then word read at 0x0010 -> mem_wn high only in the ACCESS cycle; read ack after 3 cycles with p0_rdata = 0xBEEF.
- Port 1 byte read at addr 0x0011 after that write -> p1_rdata = 0x00EF, p1_err = 0.
- Both ports request reads in the same cycle, three times in a row -> grants alternate 0, 1, 0 (with the macro defined: 0, 0, 0 while port 0 holds req).
- Port 0 word read at addr 0x07FF and byte read at 0x0800 -> ack after 2 cycles with err = 1, rdata = 0, mem_rd never asserted.
- rst_n low during an ACCESS cycle of a port 1 read -> no p1_ack; busy = 0 and all outputs 0 the next cycle; a fresh request then completes normally.
- Port 0 changes addr and wdata the cycle after grant -> memory sees only the originally latched values.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: access modes, FSM states and the latched request.
// Used by every file of the block; DATA_MEM_ARB_CPU_PRIORITY_EN only affects rr_arbiter2.
package data_mem_pkg;

    localparam int unsigned REQ_ADDR_W = 16;
    localparam int unsigned REQ_DATA_W = 16;

    localparam logic [1:0] MODE_WORD = 2'd0;
    localparam logic [1:0] MODE_BYTE = 2'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [1:0]            mode;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

    // Word accesses may not straddle the last byte; there is no wrap to address 0.
    function automatic logic req_legal(input req_t r, input int unsigned mem_bytes);
        logic [31:0] a;
        a = 32'(r.addr);
        if (r.mode > MODE_BYTE) begin
            return 1'b0;
        end
        if (a >= mem_bytes) begin
            return 1'b0;
        end
        if ((r.mode == MODE_WORD) && (a == mem_bytes - 1)) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter (request fields plus ack/rdata/err response).
// The master modport is the requester, the slave modport is the arbiter.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, mode, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, mode, addr, wdata,
        output ack, rdata, err
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-input picker: round-robin with the pointer moved on grant, or fixed port-0 priority
// when DATA_MEM_ARB_CPU_PRIORITY_EN is defined.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_gnt_id
);

    assign o_valid = |i_req;

`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN

    logic w_unused;
    assign w_unused = clk ^ rst_n ^ i_take;

    assign o_gnt_id = ~i_req[0];

`else

    // r_prio names the port that wins a tie; it flips away from whoever was granted.
    logic r_prio;

    always_comb begin
        o_gnt_id = 1'b0;
        unique case (i_req)
            2'b01:   o_gnt_id = 1'b0;
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = r_prio;
            default: o_gnt_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_take && o_valid) begin
            r_prio <= ~o_gnt_id;
        end
    end

`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: grant, one-cycle memory access, registered response.
// Define DATA_MEM_ARB_CPU_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned ADDR_W    = REQ_ADDR_W,
    parameter int unsigned DATA_W    = REQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave p0,
    data_mem_arbiter_if.slave p1,
    output logic              mem_rd,
    output logic              mem_wn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_mode,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant_id
);

    state_e            r_state;
    state_e            w_state_next;
    req_t              r_req;
    req_t              w_sel_req;
    logic              r_err;
    logic              r_gnt_id;
    logic              r_mem_rd;
    logic              r_mem_wn;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err_out;
    logic              w_mem_rd_next;
    logic              w_mem_wn_next;
    logic [1:0]        w_ack_next;
    logic [DATA_W-1:0] w_rdata_next;
    logic              w_err_out_next;
    logic [1:0]        w_req;
    logic              w_arb_valid;
    logic              w_arb_id;
    logic              w_grant;
    logic              w_legal;

    // A port whose ack is showing still holds req this cycle; keep it from being re-granted.
    assign w_req = {p1.req & ~r_ack[1], p0.req & ~r_ack[0]};

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_take   (w_grant),
        .o_valid  (w_arb_valid),
        .o_gnt_id (w_arb_id)
    );

    assign w_grant = (r_state == IDLE) && w_arb_valid;

    always_comb begin
        if (w_arb_id) begin
            w_sel_req.we    = p1.we;
            w_sel_req.mode  = p1.mode;
            w_sel_req.addr  = p1.addr;
            w_sel_req.wdata = p1.wdata;
        end else begin
            w_sel_req.we    = p0.we;
            w_sel_req.mode  = p0.mode;
            w_sel_req.addr  = p0.addr;
            w_sel_req.wdata = p0.wdata;
        end
    end

    assign w_legal = req_legal(w_sel_req, MEM_BYTES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_next = w_legal ? ACCESS : RESP;
                end
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs, so memory pins and responses come from flops.
    always_comb begin
        w_mem_rd_next  = 1'b0;
        w_mem_wn_next  = 1'b0;
        w_ack_next     = 2'b00;
        w_rdata_next   = '0;
        w_err_out_next = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid && w_legal) begin
                    w_mem_rd_next = ~w_sel_req.we;
                    w_mem_wn_next = w_sel_req.we;
                end
            end
            RESP: begin
                w_ack_next[r_gnt_id] = 1'b1;
                w_err_out_next       = r_err;
                if (!r_err && !r_req.we) begin
                    if (r_req.mode == MODE_BYTE) begin
                        w_rdata_next = {{(DATA_W-8){1'b0}}, mem_read_data[7:0]};
                    end else begin
                        w_rdata_next = mem_read_data;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req     <= '0;
            r_err     <= 1'b0;
            r_gnt_id  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wn  <= 1'b0;
            r_ack     <= 2'b00;
            r_rdata   <= '0;
            r_err_out <= 1'b0;
        end else begin
            if (w_grant) begin
                r_req    <= w_sel_req;
                r_err    <= ~w_legal;
                r_gnt_id <= w_arb_id;
            end
            r_mem_rd  <= w_mem_rd_next;
            r_mem_wn  <= w_mem_wn_next;
            r_ack     <= w_ack_next;
            r_rdata   <= w_rdata_next;
            r_err_out <= w_err_out_next;
        end
    end

    assign mem_rd         = r_mem_rd;
    assign mem_wn         = r_mem_wn;
    assign mem_address    = r_req.addr;
    assign mem_mode       = r_req.mode;
    assign mem_write_data = r_req.wdata;
    assign busy           = (r_state != IDLE);
    assign grant_id       = r_gnt_id;

    assign p0.ack   = r_ack[0];
    assign p0.rdata = r_ack[0] ? r_rdata : '0;
    assign p0.err   = r_ack[0] & r_err_out;
    assign p1.ack   = r_ack[1];
    assign p1.rdata = r_ack[1] ? r_rdata : '0;
    assign p1.err   = r_ack[1] & r_err_out;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-array memory model (writes on the falling
// edge, registered reads). Default build only (DATA_MEM_ARB_CPU_PRIORITY_EN undefined).
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_rd;
    logic        mem_wn;
    logic [15:0] mem_address;
    logic [1:0]  mem_mode;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic        busy;
    logic        grant_id;

    int n_checks = 0;
    int n_bad    = 0;

    data_mem_arbiter_if p0_if ();
    data_mem_arbiter_if p1_if ();

    data_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0             (p0_if),
        .p1             (p1_if),
        .mem_rd         (mem_rd),
        .mem_wn         (mem_wn),
        .mem_address    (mem_address),
        .mem_mode       (mem_mode),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; byte reads put junk in the upper byte so zero-extension is exercised.
    logic [7:0] mem [0:2047];

    always @(negedge clk) begin
        if (mem_wn) begin
            if (mem_mode == 2'd0) begin
                mem[mem_address[10:0]]         <= mem_write_data[15:8];
                mem[mem_address[10:0] + 11'd1] <= mem_write_data[7:0];
            end else begin
                mem[mem_address[10:0]] <= mem_write_data[7:0];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_rd) begin
            if (mem_mode == 2'd0) begin
                mem_read_data <= {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};
            end else begin
                mem_read_data <= {8'hA5, mem[mem_address[10:0]]};
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic [1:0] mode,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.mode = mode;
            p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.mode = mode;
            p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    function automatic logic ack_of(input int port);
        return (port == 0) ? p0_if.ack : p1_if.ack;
    endfunction

    function automatic logic [15:0] rdata_of(input int port);
        return (port == 0) ? p0_if.rdata : p1_if.rdata;
    endfunction

    function automatic logic err_of(input int port);
        return (port == 0) ? p0_if.err : p1_if.err;
    endfunction

    // Single transaction; perturb changes addr/wdata right after the grant edge.
    task automatic txn(input string tag, input int port, input logic we, input logic [1:0] mode,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rdata, input logic exp_err, input bit perturb);
        int          lat, rd_cnt, wn_cnt, both_cnt;
        logic [15:0] seen_addr, seen_wd, got_rdata;
        logic [1:0]  seen_mode;
        logic        got_err, got_gid;
        lat = 99; rd_cnt = 0; wn_cnt = 0; both_cnt = 0;
        seen_addr = '0; seen_wd = '0; seen_mode = '0;
        got_rdata = '1; got_err = 1'bx; got_gid = 1'bx;
        drive(port, 1'b1, we, mode, addr, wdata);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1 && perturb) drive(port, 1'b1, we, mode, addr ^ 16'h0010, ~wdata);
            if (mem_rd) rd_cnt++;
            if (mem_wn) wn_cnt++;
            if (mem_rd && mem_wn) both_cnt++;
            if (mem_rd || mem_wn) begin
                seen_addr = mem_address; seen_wd = mem_write_data; seen_mode = mem_mode;
            end
            if (ack_of(port)) begin
                lat = k; got_rdata = rdata_of(port); got_err = err_of(port); got_gid = grant_id;
                break;
            end
        end
        check_eq({tag, " latency"}, lat, exp_err ? 2 : 3);
        check_eq({tag, " rdata"}, got_rdata, exp_rdata);
        check_eq({tag, " err"}, got_err, exp_err);
        check_eq({tag, " grant_id"}, got_gid, port[0]);
        check_eq({tag, " mem_rd cycles"}, rd_cnt, (!exp_err && !we) ? 1 : 0);
        check_eq({tag, " mem_wn cycles"}, wn_cnt, (!exp_err && we) ? 1 : 0);
        check_eq({tag, " rd and wn together"}, both_cnt, 0);
        if (!exp_err) begin
            check_eq({tag, " mem_address"}, seen_addr, addr);
            check_eq({tag, " mem_mode"}, seen_mode, mode);
            if (we) check_eq({tag, " mem_write_data"}, seen_wd, wdata);
        end
        drive(port, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        tick();
        check_eq({tag, " ack one cycle"}, ack_of(port), 1'b0);
        check_eq({tag, " idle after"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int          lat, acks;
        logic        which;
        logic [15:0] got_rd;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem_read_data = 16'h0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset grant_id", grant_id, 1'b0);
        check_eq("reset mem_rd", mem_rd, 1'b0);
        check_eq("reset mem_wn", mem_wn, 1'b0);
        check_eq("reset mem_address", mem_address, 16'h0);
        check_eq("reset acks", {p1_if.ack, p0_if.ack}, 2'b00);

        txn("p0 word write", 0, 1'b1, 2'd0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        txn("p0 word read", 0, 1'b0, 2'd0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        txn("p1 byte read", 1, 1'b0, 2'd1, 16'h0011, 16'h0000, 16'h00EF, 1'b0, 1'b0);

        // Simultaneous requests, both re-raised together each round: expect 0, 1, 0.
        for (int r = 0; r < 3; r++) begin
            drive(0, 1'b1, 1'b0, 2'd0, 16'h0010, 16'h0);
            drive(1, 1'b1, 1'b0, 2'd0, 16'h0010, 16'h0);
            lat = 99; which = 1'bx; got_rd = '0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (p0_if.ack || p1_if.ack) begin
                    lat = k; which = p1_if.ack; got_rd = p1_if.ack ? p1_if.rdata : p0_if.rdata;
                    break;
                end
            end
            check_eq($sformatf("rr round %0d winner", r), which, r[0]);
            check_eq($sformatf("rr round %0d latency", r), lat, 3);
            check_eq($sformatf("rr round %0d rdata", r), got_rd, 16'hBEEF);
            drive(0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
            drive(1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
            tick();
        end

        // Both held: port 1 is favoured now, port 0 follows one slot (3 cycles) later.
        drive(0, 1'b1, 1'b0, 2'd0, 16'h0010, 16'h0);
        drive(1, 1'b1, 1'b0, 2'd1, 16'h0010, 16'h0);
        lat = 99;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (p1_if.ack) begin
                check_eq("hold p1 first latency", k, 3);
                check_eq("hold p1 byte rdata", p1_if.rdata, 16'h00BE);
                drive(1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
            end
            if (p0_if.ack) begin
                lat = k;
                break;
            end
        end
        check_eq("hold p0 second latency", lat, 6);
        drive(0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        tick();

        txn("p1 byte write 7FF", 1, 1'b1, 2'd1, 16'h07FF, 16'h775A, 16'h0000, 1'b0, 1'b0);
        txn("p0 byte read 7FF", 0, 1'b0, 2'd1, 16'h07FF, 16'h0000, 16'h005A, 1'b0, 1'b0);
        txn("p0 word read 7FE", 0, 1'b0, 2'd0, 16'h07FE, 16'h0000, 16'h005A, 1'b0, 1'b0);
        txn("p0 word read 7FF", 0, 1'b0, 2'd0, 16'h07FF, 16'h0000, 16'h0000, 1'b1, 1'b0);
        txn("p0 byte read 800", 0, 1'b0, 2'd1, 16'h0800, 16'h0000, 16'h0000, 1'b1, 1'b0);
        txn("p0 mode 2 read", 0, 1'b0, 2'd2, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0);
        txn("p1 word write 800", 1, 1'b1, 2'd0, 16'h0800, 16'h1111, 16'h0000, 1'b1, 1'b0);

        // Reset asserted during the ACCESS cycle of a port 1 read.
        drive(1, 1'b1, 1'b0, 2'd0, 16'h0010, 16'h0);
        tick();
        check_eq("mid-reset access busy", busy, 1'b1);
        check_eq("mid-reset access mem_rd", mem_rd, 1'b1);
        rst_n = 1'b0;
        tick();
        check_eq("mid-reset busy", busy, 1'b0);
        check_eq("mid-reset mem_rd", mem_rd, 1'b0);
        check_eq("mid-reset mem_address", mem_address, 16'h0);
        check_eq("mid-reset grant_id", grant_id, 1'b0);
        acks = int'(p1_if.ack);
        repeat (3) begin
            tick();
            acks += int'(p1_if.ack);
        end
        check_eq("mid-reset no p1 ack", acks, 0);
        drive(1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        rst_n = 1'b1;
        tick();
        txn("p1 read after reset", 1, 1'b0, 2'd0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

        // Fields changed after grant must not reach memory.
        txn("p0 perturbed write", 0, 1'b1, 2'd0, 16'h0020, 16'h1234, 16'h0000, 1'b0, 1'b1);
        txn("p0 read latched addr", 0, 1'b0, 2'd0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 1'b0);
        txn("p0 read changed addr", 0, 1'b0, 2'd0, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
